// File: rtl/pc_seq_if.sv
// pc_seq_if -- instruction-fetch bus between the sequencer and instruction memory.
//
// Handshake: the master holds mem_req high with mem_addr stable for as long as
// it waits for an instruction word. The slave answers by raising mem_ack for one
// cycle with the word on mem_data in that same cycle; that cycle completes the
// transfer. mem_ack seen while mem_req is low carries no meaning and is ignored.
//
// Signals:
//   mem_req  (master->slave)  fetch request
//   mem_addr (master->slave)  16-bit fetch address
//   mem_ack  (slave->master)  data on mem_data is valid this cycle
//   mem_data (slave->master)  16-bit instruction word
interface pc_seq_if;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_data;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_data
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_data
  );
endinterface

// File: rtl/pc_seq.sv
// pc_seq -- fetch/execute sequencer that drives an external program counter.
//
// Steps through INIT -> FETCH -> EXEC, parking in IDLE when run is low, stopping
// in HALT on a detected self-loop jump, and in ERROR when instruction memory
// fails to answer within TIMEOUT+1 fetch cycles. All outputs are a decode of the
// registered state, the latched instruction and the live inputs.
//
// Ports:
//   clock, reset     system clock, synchronous active-high reset
//   run              allow execution; low parks in IDLE after the current instr
//   pc_q             current external PC value (fetch address, self-loop check)
//   a_val            A-register value, jump target
//   zr, ng           ALU flags for the instruction in EXEC
//   mem              instruction-fetch bus (master side)
//   pc_reset/pc_load/pc_inc/pc_in  external PC control
//   instr, exec      latched instruction word, EXEC strobe
//   halted, err      HALT / ERROR state flags
//   retired          executed-instruction count (wraps at 2^16)
//   state_o          current FSM state for observation
module pc_seq #(
  parameter int TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic [15:0] pc_q,
  input  logic [15:0] a_val,
  input  logic        zr,
  input  logic        ng,
  pc_seq_if.master    mem,
  output logic        pc_reset,
  output logic        pc_load,
  output logic        pc_inc,
  output logic [15:0] pc_in,
  output logic [15:0] instr,
  output logic        exec,
  output logic        halted,
  output logic        err,
  output logic [15:0] retired,
  output logic [2:0]  state_o
);

  localparam int WW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_FETCH = 3'd2,
    S_EXEC  = 3'd3,
    S_HALT  = 3'd4,
    S_ERROR = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [15:0]     instr_q, instr_d;
  logic [15:0]     retired_q, retired_d;
  logic [WW-1:0]   wait_q, wait_d;

  logic            mem_req_c;
  logic [15:0]     mem_addr_c;
  logic            taken;
  logic            self_loop;

  // Jump decode; an A-instruction (bit 15 clear) never jumps.
  assign taken = instr_q[15] &
                 ((instr_q[2] & ng) | (instr_q[1] & zr) | (instr_q[0] & ~ng & ~zr));

  // Unconditional jump to the instruction's own address can never make progress.
  assign self_loop = instr_q[15] & (instr_q[2:0] == 3'b111) & (a_val == pc_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_INIT;
      instr_q   <= '0;
      retired_q <= '0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
      wait_q    <= wait_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    retired_d  = retired_q;
    wait_d     = wait_q;
    mem_req_c  = 1'b0;
    mem_addr_c = '0;
    pc_reset   = 1'b0;
    pc_load    = 1'b0;
    pc_inc     = 1'b0;
    pc_in      = '0;
    exec       = 1'b0;
    halted     = 1'b0;
    err        = 1'b0;

    unique case (state_q)
      S_INIT: begin
        pc_reset = 1'b1;
        if (run) begin
          state_d = S_FETCH;
          wait_d  = '0;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_IDLE: begin
        if (run) begin
          state_d = S_FETCH;
          wait_d  = '0;
        end
      end

      S_FETCH: begin
        mem_req_c  = 1'b1;
        mem_addr_c = pc_q;
        if (mem.mem_ack) begin
          instr_d = mem.mem_data;
          state_d = S_EXEC;
        end else if (wait_q == WW'(TIMEOUT)) begin
          // Counter already at TIMEOUT: this was fetch cycle TIMEOUT+1.
          state_d = S_ERROR;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      S_EXEC: begin
        exec      = 1'b1;
        retired_d = retired_q + 16'd1;
        if (taken) begin
          pc_load = 1'b1;
          pc_in   = a_val;
        end else begin
          pc_inc  = 1'b1;
        end
        if (self_loop) begin
          state_d = S_HALT;
        end else if (run) begin
          state_d = S_FETCH;
          wait_d  = '0;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_HALT:  halted = 1'b1;

      S_ERROR: err = 1'b1;

      default: state_d = S_INIT;
    endcase

    // Reset overrides the registers at the edge; silence the side effects now
    // so an abandoned instruction issues no PC control or fetch.
    if (reset) begin
      mem_req_c  = 1'b0;
      mem_addr_c = '0;
      pc_reset   = 1'b0;
      pc_load    = 1'b0;
      pc_inc     = 1'b0;
      pc_in      = '0;
      exec       = 1'b0;
    end
  end

  assign mem.mem_req  = mem_req_c;
  assign mem.mem_addr = mem_addr_c;
  assign instr        = instr_q;
  assign retired      = retired_q;
  assign state_o      = state_q;

endmodule
